// File: rtl/shared_adder_arb.sv
// shared_adder_arb: N requesters share one external 16-bit adder.
// A round-robin pointer selects the requester, its operands are steered to
// the adder, and the combinational sum is captured into a single result slot.
//
// Handshake rules (all interfaces): a transfer happens on a rising clock edge
// where valid and ready are both high in the preceding cycle. Requesters hold
// req_valid/req_a/req_b until accepted or may withdraw freely. The result
// slot holds resp_valid/resp_id/resp_sum stable until resp_ready is seen.
module shared_adder_arb #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N-1:0]    req_valid,
  input  logic [N*16-1:0] req_a,
  input  logic [N*16-1:0] req_b,
  output logic [N-1:0]    req_ready,
  output logic [15:0]     add_a,
  output logic [15:0]     add_b,
  input  logic [15:0]     add_s,
  output logic            resp_valid,
  output logic [IW-1:0]   resp_id,
  output logic [15:0]     resp_sum,
  input  logic            resp_ready
);

  // Round-robin pointer and result slot registers.
  logic [IW-1:0] ptr_q, ptr_d;
  logic          resp_valid_q, resp_valid_d;
  logic [IW-1:0] resp_id_q, resp_id_d;
  logic [15:0]   resp_sum_q, resp_sum_d;

  // Arbitration intermediates.
  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic           gnt_vld;
  logic [IW-1:0]  gnt_idx;
  logic [N-1:0]   gnt_oh;
  logic           slot_free;
  logic           accept;

  // Rotate requests so bit 0 is the pointer's requester, then pick the first set bit.
  always_comb begin
    logic [IW:0] idx_sum;
    req_dbl = {req_valid, req_valid};
    req_rot = req_dbl[N-1:0];
    req_rot = N'(req_dbl >> ptr_q);
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx_sum = '0;
    for (int k = 0; k < N; k++) begin
      if (!gnt_vld && req_rot[k]) begin
        gnt_vld = 1'b1;
        idx_sum = {1'b0, ptr_q} + (IW+1)'(k);
        if (idx_sum >= (IW+1)'(N)) begin
          idx_sum = idx_sum - (IW+1)'(N);
        end
        gnt_idx = idx_sum[IW-1:0];
      end
    end
  end

  // Decode the granted index to one-hot; suppressed entirely while in reset.
  always_comb begin
    gnt_oh = '0;
    for (int i = 0; i < N; i++) begin
      if (rstn && gnt_vld && (gnt_idx == IW'(i))) begin
        gnt_oh[i] = 1'b1;
      end
    end
  end

  // The slot can take a new result if it is empty or being drained this cycle.
  always_comb begin
    slot_free = !resp_valid_q || resp_ready;
    accept    = rstn && gnt_vld && slot_free;
    req_ready = accept ? gnt_oh : '0;
  end

  // Steer the granted requester's operands to the shared adder; zero otherwise.
  always_comb begin
    add_a = 16'h0000;
    add_b = 16'h0000;
    for (int i = 0; i < N; i++) begin
      if (gnt_oh[i]) begin
        add_a = req_a[16*i +: 16];
        add_b = req_b[16*i +: 16];
      end
    end
  end

  // Next-state for the pointer and result slot.
  always_comb begin
    ptr_d        = ptr_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_sum_d   = resp_sum_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_id_d    = gnt_idx;
      resp_sum_d   = add_s;
      if (gnt_idx == IW'(N-1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx + IW'(1);
      end
    end else if (resp_valid_q && resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_sum_q   <= 16'h0000;
    end else begin
      ptr_q        <= ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_sum_q   <= resp_sum_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_sum   = resp_sum_q;

endmodule
